// File: rtl/pc_pkg.sv
// Shared types for the program counter with return-address stack.
// Op encoding doubles as priority: a larger value wins when several ops are asserted.
package pc_pkg;

    localparam logic [2:0] PRI_NONE   = 3'd0;
    localparam logic [2:0] PRI_INC    = 3'd1;
    localparam logic [2:0] PRI_BRANCH = 3'd2;
    localparam logic [2:0] PRI_RET    = 3'd3;
    localparam logic [2:0] PRI_CALL   = 3'd4;
    localparam logic [2:0] PRI_LOAD   = 3'd5;

    typedef enum logic [2:0] {
        OP_NONE   = PRI_NONE,
        OP_INC    = PRI_INC,
        OP_BRANCH = PRI_BRANCH,
        OP_RET    = PRI_RET,
        OP_CALL   = PRI_CALL,
        OP_LOAD   = PRI_LOAD
    } pc_op_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_call_stack_ret_stack.sv
// LIFO of return addresses; caller gates push/pop against full/empty.
// Storage is not reset; only the occupancy counter is.
module ret_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic [sp_width(DEPTH)-1:0]    sp,
    output logic                          full,
    output logic                          empty
);

    localparam int SPW = sp_width(DEPTH);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [SPW-1:0]   top_idx;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign top_idx = sp_q - SPW'(1);
    assign wr_idx  = sp_q[AW-1:0];
    assign rd_idx  = top_idx[AW-1:0];

    assign rdata = mem_q[rd_idx];
    assign sp    = sp_q;
    assign empty = (sp_q == '0);
    assign full  = (sp_q == SPW'(DEPTH));

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_call_stack.sv
// Fetch-path program counter with load, call/ret, relative branch and increment.
// Define PC_STACK_TRAP_EN to redirect stack faults to TRAP_VEC.
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = 16'h0,
    parameter logic [WIDTH-1:0] TRAP_VEC  = 16'hFFF0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          call,
    input  logic                          ret,
    input  logic                          branch,
    input  logic                          inc,
    input  logic [WIDTH-1:0]              in,
    input  logic [WIDTH-1:0]              off,
    output logic [WIDTH-1:0]              out,
    output logic [sp_width(DEPTH)-1:0]    sp,
    output logic                          empty,
    output logic                          full,
    output logic                          ovf,
    output logic                          unf
);

    pc_op_e           op;
    logic [WIDTH-1:0] pc_q,  pc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0] pc_plus1;

    assign pc_plus1 = pc_q + WIDTH'(1);

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (pc_plus1),
        .rdata (ret_addr),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        op = OP_NONE;
        if (load) begin
            op = OP_LOAD;
        end else if (call) begin
            op = OP_CALL;
        end else if (ret) begin
            op = OP_RET;
        end else if (branch) begin
            op = OP_BRANCH;
        end else if (inc) begin
            op = OP_INC;
        end
    end

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        pop   = 1'b0;
        case (op)
            OP_LOAD: pc_d = in;
            OP_CALL: begin
                if (!full) begin
                    push = 1'b1;
                    pc_d = in;
                end else begin
                    ovf_d = 1'b1;
`ifdef PC_STACK_TRAP_EN
                    pc_d  = TRAP_VEC;
`else
                    pc_d  = in;
`endif
                end
            end
            OP_RET: begin
                if (!empty) begin
                    pop  = 1'b1;
                    pc_d = ret_addr;
                end else begin
                    unf_d = 1'b1;
`ifdef PC_STACK_TRAP_EN
                    pc_d  = TRAP_VEC;
`endif
                end
            end
            OP_BRANCH: pc_d = pc_q + off;
            OP_INC:    pc_d = pc_plus1;
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign out = pc_q;
    assign ovf = ovf_q;
    assign unf = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: directed scenarios plus randomized ops vs a queue-based model.
// Build with PC_STACK_TRAP_EN defined to check the trap variant.
module tb_pc_call_stack;

    localparam int          WIDTH     = 16;
    localparam int          DEPTH     = 8;
    localparam logic [15:0] RESET_VEC = 16'h0;
    localparam logic [15:0] TRAP_VEC  = 16'hFFF0;
`ifdef PC_STACK_TRAP_EN
    localparam bit          TRAP      = 1'b1;
`else
    localparam bit          TRAP      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, load, call, ret, branch, inc;
    logic [15:0] in, off;
    logic [15:0] out;
    logic [3:0]  sp;
    logic        empty, full, ovf, unf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_ovf, m_unf;

    pc_call_stack #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .call(call), .ret(ret),
        .branch(branch), .inc(inc), .in(in), .off(off), .out(out), .sp(sp),
        .empty(empty), .full(full), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model by the spec's priority rules, step past the edge.
    task automatic apply(input logic r, l, c, rt, b, i, input logic [15:0] tin, toff);
        reset = r; load = l; call = c; ret = rt; branch = b; inc = i; in = tin; off = toff;
        if (r) begin
            m_pc = RESET_VEC; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (l) begin
            m_pc = tin;
        end else if (c) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(m_pc + 16'd1);
                m_pc = tin;
            end else begin
                m_ovf = 1'b1;
                m_pc  = TRAP ? TRAP_VEC : tin;
            end
        end else if (rt) begin
            if (m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                m_unf = 1'b1;
                if (TRAP) m_pc = TRAP_VEC;
            end
        end else if (b) begin
            m_pc = m_pc + toff;
        end else if (i) begin
            m_pc = m_pc + 16'd1;
        end
        @(posedge clk);
        #1;
        {reset, load, call, ret, branch, inc} = '0;
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        checks++; if (out !== RESET_VEC) begin errors++; $display("FAIL reset_out: got %h want %h", out, RESET_VEC); end
        checks++; if (sp !== 4'd0) begin errors++; $display("FAIL reset_sp: got %0d want 0", sp); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b want 10", empty, full); end
        checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", ovf, unf); end
        for (int k = 0; k < 3; k++) apply(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
        checks++; if (out !== 16'h0003) begin errors++; $display("FAIL inc3: got %h want 0003", out); end
    endtask

    task automatic test_wrap();
        apply(0, 1, 0, 0, 0, 0, 16'hFFFF, 16'h0);
        apply(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL inc_wrap: got %h want 0000", out); end
        apply(0, 1, 0, 0, 0, 0, 16'h0002, 16'h0);
        apply(0, 0, 0, 0, 1, 0, 16'h0, 16'hFFFC);
        checks++; if (out !== 16'hFFFE) begin errors++; $display("FAIL branch_back_wrap: got %h want FFFE", out); end
        apply(0, 0, 0, 0, 1, 0, 16'h0, 16'h0005);
        checks++; if (out !== 16'h0003) begin errors++; $display("FAIL branch_fwd_wrap: got %h want 0003", out); end
    endtask

    task automatic test_call_ret();
        apply(0, 1, 0, 0, 0, 0, 16'h0010, 16'h0);
        apply(0, 0, 1, 0, 0, 0, 16'h0200, 16'h0);
        checks++; if (out !== 16'h0200 || sp !== 4'd1) begin errors++; $display("FAIL call: got out=%h sp=%0d want 0200 1", out, sp); end
        apply(0, 0, 0, 1, 0, 0, 16'h0, 16'h0);
        checks++; if (out !== 16'h0011 || sp !== 4'd0) begin errors++; $display("FAIL ret: got out=%h sp=%0d want 0011 0", out, sp); end
        apply(0, 1, 0, 0, 0, 0, 16'hFFFF, 16'h0);
        apply(0, 0, 1, 0, 0, 0, 16'h0100, 16'h0);
        apply(0, 0, 0, 1, 0, 0, 16'h0, 16'h0);
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL ret_addr_wrap: got %h want 0000", out); end
    endtask

    task automatic test_priority();
        apply(0, 1, 1, 0, 0, 1, 16'h0040, 16'h0);
        checks++; if (out !== 16'h0040 || sp !== 4'd0) begin errors++; $display("FAIL load_over_call: got out=%h sp=%0d want 0040 0", out, sp); end
        apply(0, 0, 1, 1, 1, 1, 16'h0080, 16'h0010);
        checks++; if (out !== 16'h0080 || sp !== 4'd1) begin errors++; $display("FAIL call_over_ret: got out=%h sp=%0d want 0080 1", out, sp); end
        apply(0, 0, 0, 1, 1, 1, 16'h0, 16'h0010);
        checks++; if (out !== 16'h0041 || sp !== 4'd0) begin errors++; $display("FAIL ret_over_branch: got out=%h sp=%0d want 0041 0", out, sp); end
        apply(0, 0, 0, 0, 1, 1, 16'h0, 16'h0010);
        checks++; if (out !== 16'h0051) begin errors++; $display("FAIL branch_over_inc: got %h want 0051", out); end
    endtask

    task automatic test_faults();
        logic [15:0] exp_ret;
        apply(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        for (int k = 0; k < DEPTH; k++) apply(0, 0, 1, 0, 0, 0, 16'h1000 + 16'(k * 16), 16'h0);
        checks++; if (full !== 1'b1 || ovf !== 1'b0 || sp !== 4'(DEPTH)) begin errors++; $display("FAIL fill: got full=%b ovf=%b sp=%0d want 1 0 %0d", full, ovf, sp, DEPTH); end
        apply(0, 0, 1, 0, 0, 0, 16'h2222, 16'h0);
        checks++; if (ovf !== 1'b1 || sp !== 4'(DEPTH) || full !== 1'b1) begin errors++; $display("FAIL overflow: got ovf=%b sp=%0d full=%b want 1 %0d 1", ovf, sp, full, DEPTH); end
        checks++; if (out !== (TRAP ? TRAP_VEC : 16'h2222)) begin errors++; $display("FAIL overflow_pc: got %h want %h", out, TRAP ? TRAP_VEC : 16'h2222); end
        for (int k = DEPTH - 1; k >= 0; k--) begin
            exp_ret = (k == 0) ? 16'h0001 : 16'h1000 + 16'((k - 1) * 16) + 16'h1;
            apply(0, 0, 0, 1, 0, 0, 16'h0, 16'h0);
            checks++; if (out !== exp_ret) begin errors++; $display("FAIL unwind_%0d: got %h want %h", k, out, exp_ret); end
        end
        checks++; if (empty !== 1'b1 || unf !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL unwound: got empty=%b unf=%b ovf=%b want 1 0 1", empty, unf, ovf); end
        apply(0, 0, 0, 1, 0, 0, 16'h0, 16'h0);
        checks++; if (unf !== 1'b1 || sp !== 4'd0) begin errors++; $display("FAIL underflow: got unf=%b sp=%0d want 1 0", unf, sp); end
        checks++; if (out !== (TRAP ? TRAP_VEC : 16'h0001)) begin errors++; $display("FAIL underflow_pc: got %h want %h", out, TRAP ? TRAP_VEC : 16'h0001); end
        apply(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
        checks++; if (unf !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL sticky: got ovf=%b unf=%b want 1 1", ovf, unf); end
    endtask

    task automatic test_reset_during_call();
        apply(0, 1, 0, 0, 0, 0, 16'h0005, 16'h0);
        apply(0, 0, 1, 0, 0, 0, 16'h0300, 16'h0);
        apply(1, 0, 1, 0, 0, 0, 16'h0400, 16'h0);
        checks++; if (out !== RESET_VEC || sp !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
            errors++; $display("FAIL reset_with_call: got out=%h sp=%0d ovf=%b unf=%b want %h 0 0 0", out, sp, ovf, unf, RESET_VEC);
        end
        apply(0, 0, 0, 1, 0, 0, 16'h0, 16'h0);
        checks++; if (unf !== 1'b1 || sp !== 4'd0) begin errors++; $display("FAIL no_push_on_reset: got unf=%b sp=%0d want 1 0", unf, sp); end
    endtask

    task automatic test_random();
        int call_w;
        int ret_w;
        for (int n = 0; n < 600; n++) begin
            call_w = (n % 200 < 100) ? 4 : 1;
            ret_w  = (n % 200 < 100) ? 1 : 4;
            apply(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < call_w),
                  ($urandom_range(0, 9) < ret_w),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 0),
                  16'($urandom), 16'($urandom));
            checks++;
            if (out !== m_pc || sp !== 4'(m_stk.size()) || empty !== (m_stk.size() == 0) ||
                full !== (m_stk.size() == DEPTH) || ovf !== m_ovf || unf !== m_unf) begin
                errors++;
                $display("FAIL random_%0d: got out=%h sp=%0d e=%b f=%b ovf=%b unf=%b want %h %0d %b %b %b %b",
                         n, out, sp, empty, full, ovf, unf, m_pc, m_stk.size(),
                         (m_stk.size() == 0), (m_stk.size() == DEPTH), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        {reset, load, call, ret, branch, inc} = '0;
        in = '0; off = '0;
        m_pc = RESET_VEC; m_ovf = 1'b0; m_unf = 1'b0;
        #2;
        test_reset();
        test_wrap();
        test_call_ret();
        test_priority();
        test_faults();
        test_reset_during_call();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
